// File: rtl/ifetch_btb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_btb_pkg : shared constants and counter helpers for ifetch_btb  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package ifetch_btb_pkg;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [1:0]  CTR_SNT   = 2'd0;
  localparam logic [1:0]  CTR_WNT   = 2'd1;
  localparam logic [1:0]  CTR_WT    = 2'd2;
  localparam logic [1:0]  CTR_ST    = 2'd3;
  localparam logic [1:0]  CTR_ALLOC = CTR_WT;

  typedef enum logic [1:0] {
    BTB_NOP   = 2'd0,
    BTB_TRAIN = 2'd1,
    BTB_ALLOC = 2'd2,
    BTB_INVAL = 2'd3
  } btb_op_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
    else       return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

  function automatic logic ctr_taken(input logic [1:0] c);
    return (c == CTR_WT) || (c == CTR_ST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_btb_btb_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btb_table : direct-mapped BTB, combinational lookup, sync update      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module btb_table
  import ifetch_btb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] rd_word_i,
  output logic              rd_hit_o,
  output logic [ADDR_W-1:0] rd_target_o,
  output logic [1:0]        rd_ctr_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-3:0] wr_word_i,
  input  logic              wr_is_branch_i,
  input  logic              wr_taken_i,
  input  logic [ADDR_W-1:0] wr_target_i
);

  localparam int IDX   = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - 2 - IDX;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic [1:0]        ctr_q    [DEPTH];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             wr_hit;
  btb_op_e          op;

  assign rd_idx = rd_word_i[IDX-1:0];
  assign rd_tag = rd_word_i[ADDR_W-3:IDX];
  assign wr_idx = wr_word_i[IDX-1:0];
  assign wr_tag = wr_word_i[ADDR_W-3:IDX];

  // Reads see pre-edge contents, so a same-cycle write is never bypassed.
  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target_o = target_q[rd_idx];
  assign rd_ctr_o    = ctr_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    op = BTB_NOP;
    if (wr_en_i) begin
      if (wr_is_branch_i) begin
        if (wr_hit)          op = BTB_TRAIN;
        else if (wr_taken_i) op = BTB_ALLOC;
      end else if (wr_hit) begin
        op = BTB_INVAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      case (op)
        BTB_TRAIN: begin
          ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken_i);
          if (wr_taken_i) target_q[wr_idx] <= wr_target_i;
        end
        BTB_ALLOC: begin
          valid_q[wr_idx]  <= 1'b1;
          tag_q[wr_idx]    <= wr_tag;
          target_q[wr_idx] <= wr_target_i;
          ctr_q[wr_idx]    <= CTR_ALLOC;
        end
        BTB_INVAL: valid_q[wr_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_btb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_btb : IF stage with PC, IF/ID register and BTB next-PC predict |
// | Option: IFETCH_PERF_EN adds perf_resolved/branches/mispredicts       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ifetch_btb
  import ifetch_btb_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               INST_W    = 32,
  parameter int               BTB_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              cpu_rst,
  input  logic              cpu_en,
  input  logic              stall,
  output logic              inst_ren,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_data,
  output logic [INST_W-1:0] if_id_ir,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_next,
  output logic              if_id_valid,
  output logic              if_id_pred_taken,
  input  logic              resolve_valid,
  input  logic              resolve_is_branch,
  input  logic              resolve_taken,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic              redirect
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_resolved,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [ADDR_W-1:0] id_pcn_q, id_pcn_d;
  logic              id_valid_q, id_valid_d;
  logic              id_pred_q, id_pred_d;
  logic [ADDR_W-1:0] id_pnext_q, id_pnext_d;

  logic              btb_hit;
  logic [ADDR_W-1:0] btb_target;
  logic [1:0]        btb_ctr;
  logic              pred_taken;
  logic [ADDR_W-1:0] pc_plus4, pred_next, actual_next;
  logic              eval, mispredict;

  btb_table #(
    .ADDR_W (ADDR_W),
    .DEPTH  (BTB_DEPTH)
  ) u_btb (
    .clk            (clk),
    .rst            (cpu_rst),
    .rd_word_i      (pc_q[ADDR_W-1:2]),
    .rd_hit_o       (btb_hit),
    .rd_target_o    (btb_target),
    .rd_ctr_o       (btb_ctr),
    .wr_en_i        (eval),
    .wr_word_i      (id_pc_q[ADDR_W-1:2]),
    .wr_is_branch_i (resolve_is_branch),
    .wr_taken_i     (resolve_taken),
    .wr_target_i    (resolve_target)
  );

  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign pred_taken = btb_hit && ctr_taken(btb_ctr);
  assign pred_next  = pred_taken ? btb_target : pc_plus4;

  // A resolution only counts when it can actually act this cycle.
  assign eval        = resolve_valid && id_valid_q && !stall && cpu_en && !cpu_rst;
  assign actual_next = resolve_taken ? resolve_target : id_pcn_q;
  assign mispredict  = eval && (actual_next != id_pnext_q);

  assign redirect         = mispredict;
  assign inst_ren         = !cpu_rst;
  assign inst_addr        = cpu_rst ? RESET_PC : pc_q;
  assign if_id_ir         = ir_q;
  assign if_id_pc         = id_pc_q;
  assign if_id_pc_next    = id_pcn_q;
  assign if_id_valid      = id_valid_q;
  assign if_id_pred_taken = id_pred_q;

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    id_pc_d    = id_pc_q;
    id_pcn_d   = id_pcn_q;
    id_valid_d = id_valid_q;
    id_pred_d  = id_pred_q;
    id_pnext_d = id_pnext_q;
    if (cpu_en) begin
      if (mispredict) begin
        pc_d       = actual_next;
        ir_d       = INST_W'(NOP);
        id_valid_d = 1'b0;
        id_pred_d  = 1'b0;
      end else if (!stall) begin
        pc_d       = pred_next;
        ir_d       = inst_data;
        id_pc_d    = pc_q;
        id_pcn_d   = pc_plus4;
        id_valid_d = 1'b1;
        id_pred_d  = pred_taken;
        id_pnext_d = pred_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= INST_W'(NOP);
      id_pc_q    <= '0;
      id_pcn_q   <= '0;
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
      id_pnext_q <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      id_pc_q    <= id_pc_d;
      id_pcn_q   <= id_pcn_d;
      id_valid_q <= id_valid_d;
      id_pred_q  <= id_pred_d;
      id_pnext_q <= id_pnext_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_res_q, perf_br_q, perf_mis_q;

  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      perf_res_q <= '0;
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      if (eval)                      perf_res_q <= perf_res_q + 32'd1;
      if (eval && resolve_is_branch) perf_br_q  <= perf_br_q + 32'd1;
      if (mispredict)                perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_resolved    = perf_res_q;
  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`endif

endmodule
`default_nettype wire

// File: doc/ifetch_btb.md
Name: ifetch_btb

Overview:
Parametrised fetch stage for the 5-stage MIPS pipeline. It owns the PC, the IF/ID pipeline register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Branches and jumps still resolve in ID; this block predicts next-PC at fetch, so a correctly predicted taken branch costs no redirect. On a mispredict it redirects the PC and flushes IF/ID. It also adds stall support, which the current IF stage lacks.

Parameters:
ADDR_W, 32, PC / instruction address width
INST_W, 32, instruction width
BTB_DEPTH, 16, BTB entries; power of two, minimum 2
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  main clock
cpu_rst  in  1  synchronous active-high reset
cpu_en  in  1  global enable; when 0 all state holds
stall  in  1  hold PC and IF/ID (load-use hazard from ID)
inst_ren  out  1  instruction read enable
inst_addr  out  ADDR_W  current PC to instruction memory
inst_data  in  INST_W  instruction for inst_addr, same cycle (combinational memory)
if_id_ir  out  INST_W  IF/ID instruction
if_id_pc  out  ADDR_W  IF/ID instruction address
if_id_pc_next  out  ADDR_W  if_id_pc+4
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pred_taken  out  1  fetch predicted this instruction taken
resolve_valid  in  1  ID resolution for the instruction in IF/ID is present
resolve_is_branch  in  1  instruction is a branch or jump (j/jal/jr/beq/bne)
resolve_taken  in  1  actual direction
resolve_target  in  ADDR_W  actual target, valid when resolve_taken
redirect  out  1  combinational; mispredict being corrected this cycle

Behaviour:
- Reset, synchronous, priority over everything:
  - inst_addr=RESET_PC, inst_ren=0 during reset and 1 otherwise.
  - if_id_ir=0 (NOP), if_id_pc=0, if_id_pc_next=0, if_id_valid=0, if_id_pred_taken=0.
  - All BTB valid bits cleared; redirect=0.
- BTB indexing: index=inst_addr[IDX+1:2], IDX=log2(BTB_DEPTH); tag=inst_addr[ADDR_W-1:IDX+2]. Entry fields: valid, tag, target, ctr[1:0].
- Prediction, combinational at IF:
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_next = pred_taken ? target : inst_addr+4. All address arithmetic is modulo 2^ADDR_W.
- Pipeline register: IF/ID also stores pred_next internally.
- Resolution, evaluated only when resolve_valid & if_id_valid & ~stall & cpu_en; otherwise ignored:
  - actual_next = resolve_taken ? resolve_target : if_id_pc_next.
  - mispredict = (actual_next != stored pred_next); redirect = mispredict.
- Per-cycle update when cpu_en=1, in priority order:
  - redirect: inst_addr<=actual_next; IF/ID<=bubble (ir=0, valid=0, pred_taken=0). The wrong-path fetch is discarded.
  - else stall: inst_addr and IF/ID hold. No BTB update.
  - else: inst_addr<=pred_next; IF/ID<={inst_data, inst_addr, inst_addr+4, pred_taken}, valid=1.
- BTB update, on any evaluated resolution, written at the clock edge (using if_id_pc):
  - Branch, entry hit, taken: ctr saturating increment; target<=resolve_target.
  - Branch, entry hit, not taken: ctr saturating decrement.
  - Branch, entry miss, taken: allocate with ctr=2'b10 (weakly taken). This replaces any occupant.
  - Branch, entry miss, not taken: no allocation.
  - Not a branch, entry hit (alias): clear valid.
- Same-cycle read/write: a BTB write and an IF lookup at the same index in the same cycle returns the old contents (no bypass).
- Counter bounds: 2'b11 saturates up, 2'b00 saturates down.
- cpu_en=0: no state changes at all, including the BTB; redirect forced to 0.
- Reset mid-redirect: reset wins; the BTB is cleared.

Optional Feature:
IFETCH_PERF_EN:
- Defined: adds outputs perf_resolved[31:0], perf_branches[31:0] and perf_mispredicts[31:0]. They count evaluated resolutions, those with resolve_is_branch=1, and redirect cycles. All three wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (define.vh style): NOP encoding 32'h0, counter state constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3, and CTR_ALLOC=CTR_WT.
- Sub-module btb_table:
  - Storage, read port: combinational lookup (hit, target, ctr).
  - Write port: synchronous single-entry update with saturating counter logic.
- ifetch_btb keeps the PC, IF/ID, mispredict compare and optional perf counters.

Test Plan:
1. Reset then free-run with no resolutions -> inst_addr sequence 0,4,8,12; if_id_valid=0 first cycle after reset, then 1; if_id_ir equals memory data.
2. Taken beq at 0x10, target 0x40, cold BTB -> redirect=1 for one cycle; next inst_addr=0x40; IF/ID bubble. Entry allocated with ctr=2. Second pass at 0x10 -> pred_taken=1, inst_addr goes 0x10->0x40 directly, redirect=0.
3. Same branch then resolved not-taken twice -> 1st: redirect to 0x14, ctr=1. 2nd: predicted not-taken, no redirect, ctr=0. A 3rd not-taken leaves ctr=0.
4. stall=1 for 3 cycles while resolve_valid=1 with a mispredict -> inst_addr and IF/ID hold; redirect=0; BTB unchanged. After stall drops, the resolution takes effect.
5. BTB_DEPTH=16, branches at 0x10 and 0x50 (same index, different tag), both taken -> the second allocation evicts the first. The next fetch of 0x10 misses and redirects again.
6. Non-branch at an aliased address with a BTB hit and pred_taken=1 -> redirect to pc+4; entry invalidated. With IFETCH_PERF_EN, perf_mispredicts increments and perf_branches does not.
